// File: rtl/arith_result_fifo.sv
// arith_result_fifo
//   First-word-fall-through result buffer placed behind the arithmetic unit.
//   Every cycle arith_flag is high the {carry_out, arith_out} pair is queued;
//   the consumer pops the head with rd_valid/rd_ready. Writes that find the
//   buffer full (and no simultaneous pop) are dropped and latch 'overflow'.
//
//   Handshake: a read transfer happens on a rising edge where rd_valid and
//   rd_ready are both high; rd_valid never depends on rd_ready, and the head
//   word is stable while rd_valid is high and rd_ready is low.
//
//   Build option: define ARITH_FIFO_CARRY_EN to store carry_out with each
//   result and return it on rd_carry; otherwise rd_carry is tied low and
//   entries are DATA_WIDTH bits wide.
module arith_result_fifo #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] arith_out,
    input  logic                  carry_out,
    input  logic                  arith_flag,
    input  logic                  rd_ready,
    input  logic                  clr_ovf,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_carry,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

`ifdef ARITH_FIFO_CARRY_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head_entry;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic                  wr_en;
    logic                  rd_fire;
    logic                  drop;

    // Status is decoded from the occupancy register only, so full and empty
    // are never ambiguous when the pointers are equal.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign rd_valid = ~empty;
    assign count    = count_q;
    assign overflow = overflow_q;

    // A pop frees a slot in the same cycle, so a write into a full buffer is
    // still accepted when the head is leaving.
    assign rd_fire = rd_valid & rd_ready;
    assign wr_en   = arith_flag & (~full | rd_fire);
    assign drop    = arith_flag & full & ~rd_fire;

    // Head word is presented straight from the array (fall-through).
    assign head_entry = mem_q[rd_ptr_q];
    assign rd_data    = head_entry[DATA_WIDTH-1:0];

`ifdef ARITH_FIFO_CARRY_EN
    assign wr_entry = {carry_out, arith_out};
    assign rd_carry = head_entry[DATA_WIDTH];
`else
    logic unused_carry;
    assign unused_carry = carry_out;
    assign wr_entry     = arith_out;
    assign rd_carry     = 1'b0;
`endif

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (wr_en && !rd_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_fire && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end

        // A dropped write wins over a clear in the same cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; not reset, stale words are unreachable once count is 0.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_arith_result_fifo.sv
// Testbench for arith_result_fifo: directed vectors with hand-computed
// expectations plus an expected-queue scoreboard for read ordering.
module tb_arith_result_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

`ifdef ARITH_FIFO_CARRY_EN
    localparam logic CARRY_ON = 1'b1;
`else
    localparam logic CARRY_ON = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic [DW-1:0] arith_out;
    logic          carry_out;
    logic          arith_flag;
    logic          rd_ready;
    logic          clr_ovf;
    logic [DW-1:0] rd_data;
    logic          rd_carry;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];
    logic          exp_ovf = 1'b0;

    arith_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .arith_out (arith_out),
        .carry_out (carry_out),
        .arith_flag(arith_flag),
        .rd_ready  (rd_ready),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .rd_carry  (rd_carry),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; the scoreboard predicts pops, pushes
    // and the overflow flag, then checks status #1 after the edge.
    task automatic cycle(input logic flag, input logic [DW-1:0] data, input logic cy,
                         input logic ready, input logic clr);
        logic        fire;
        logic        was_full;
        logic [DW:0] head;
        arith_flag = flag;
        arith_out  = data;
        carry_out  = cy;
        rd_ready   = ready;
        clr_ovf    = clr;
        was_full   = (exp_q.size() == DEPTH);
        fire       = (exp_q.size() != 0) && ready;
        if (fire) begin
            head = exp_q.pop_front();
            check("head_data", 32'(rd_data), 32'(head[DW-1:0]));
            check("head_carry", 32'(rd_carry), 32'(head[DW] & CARRY_ON));
        end
        if (flag && (!was_full || fire)) exp_q.push_back({cy, data});
        if (flag && was_full && !fire) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        @(posedge CLK);
        #1;
        arith_flag = 1'b0;
        rd_ready   = 1'b0;
        clr_ovf    = 1'b0;
        check("count", 32'(count), 32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    endtask

    task automatic drain();
        while (exp_q.size() != 0) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        RST = 1'b0; arith_out = '0; carry_out = 1'b0;
        arith_flag = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;

        // Single write, visible the cycle after the edge
        cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data", 32'(rd_data), 32'h1234);
        check("t1_carry", 32'(rd_carry), 32'(CARRY_ON));
        drain();
        check("t1_empty", 32'(empty), 32'd1);

        // Fill, overflow on ninth write, drain in order
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), i[0], 1'b0, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd8);
        cycle(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_head", 32'(rd_data), 32'h0001);
        drain();
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // Full + write + pop: both happen, no overflow, new word read last
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(16'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00AA, 1'b1, 1'b1, 1'b0);
        check("t3_count", 32'(count), 32'd8);
        check("t3_ovf", 32'(overflow), 32'd0);
        repeat (7) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t3_last", 32'(rd_data), 32'h00AA);
        drain();

        // Empty + write + ready: only the write happens
        cycle(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0);
        check("t4_count", 32'(count), 32'd1);
        check("t4_data", 32'(rd_data), 32'h0055);
        drain();

        // Streaming: one in, one out per cycle across two pointer wraps
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'(i), i[1], 1'b1, 1'b0);
            check("t5_count_le1", 32'(count <= 4'd1), 32'd1);
        end
        check("t5_tail", 32'(rd_data), 32'd19);
        drain();

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h40 + i), 1'b0, 1'b0, 1'b0);
        check("t6_pre_count", 32'(count), 32'd5);
        #2 RST = 1'b0;
        #1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_valid", 32'(rd_valid), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_full", 32'(full), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;

        // Overflow set wins over a simultaneous clear
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(16'h60 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
        check("t7_ovf_prio", 32'(overflow), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t7_ovf_clr", 32'(overflow), 32'd0);
        drain();
        check("t7_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_result_fifo.md
# arith_result_fifo

- Downstream stage of the arithmetic unit: buffers registered results (`arith_out`, `carry_out`) each cycle the arithmetic unit asserts `arith_flag`.
- Hands results to the consumer through a valid/ready first-word-fall-through interface.
- Decouples the result producer, which issues one result per enabled cycle, from slower consumers.
- Flags dropped results with a sticky overflow bit.

## Interface
- `DATA_WIDTH`, 16: width of stored result; matches the arithmetic unit's output width.
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `ADDR_WIDTH`, $clog2(DEPTH): pointer width (derived; do not override).
- `CLK` in 1: single clock, all state on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `arith_out` in DATA_WIDTH: result word from the arithmetic unit.
- `carry_out` in 1: carry/overflow bit from the arithmetic unit.
- `arith_flag` in 1: result-valid strobe; write request when high.
- `rd_ready` in 1: consumer accepts head entry.
- `clr_ovf` in 1: clears the sticky `overflow` bit.
- `rd_data` out DATA_WIDTH: head entry data.
- `rd_carry` out 1: head entry carry.
- `rd_valid` out 1: FIFO non-empty; head entry presented.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a write is dropped.

## Operation
- Storage: DEPTH-entry register array, write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy counter `count`; both pointers ADDR_WIDTH bits, wrap modulo DEPTH.
- Write accept: `wr_en = arith_flag & (~full | rd_fire)`.
  - Store `{carry_out, arith_out}` at `wr_ptr`; `wr_ptr` +1.
- Read fire: `rd_fire = rd_valid & rd_ready`; `rd_ptr` +1.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Head presentation: `rd_data`/`rd_carry` are driven combinationally from `mem[rd_ptr]`; they are undefined-but-stable when empty (implementation drives entry at `rd_ptr`).
- Status outputs: `rd_valid = ~empty`; `empty`, `full`, `count` derive from the `count` register (no pointer-compare ambiguity).
- Overflow:
  - Set when `arith_flag & full & ~rd_fire`; the incoming result is discarded and FIFO contents are untouched.
  - Cleared by `clr_ovf`. Set has priority over clear in the same cycle.
- Boundary cases:
  - Empty + `arith_flag` + `rd_ready`: only the write happens (`rd_valid` was 0); count 0→1.
  - Full + `arith_flag` + `rd_fire`: both happen; count stays DEPTH, no overflow.
  - `rd_ready` while empty: ignored, pointers hold.
  - Pointer wrap from DEPTH−1 to 0: seamless, no bubble.
- Reset (async assert, any time including mid-burst):
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0, `overflow`=0.
  - Outputs: `empty`=1, `full`=0, `rd_valid`=0.
  - `rd_data`/`rd_carry` read entry 0.
  - Memory array is not reset; stale contents are unreachable.

## Timing
- Write-to-read latency 1 cycle: `arith_flag` sampled at edge N → `rd_valid`=1 and data visible after edge N.
- Read pop effective at the sampling edge; the next entry is presented in the following cycle, giving back-to-back reads at one per cycle.
- Sustained throughput: one write and one read per cycle.
- `full`, `empty`, `count`, `overflow` are registered-state derived and update after the causing edge.
- `RST` deassertion is synchronous to `CLK` externally; the first write is accepted on the first edge with `RST`=1.

## Configuration
- `ARITH_FIFO_CARRY_EN` defined: entries are DATA_WIDTH+1 bits and `carry_out` is stored and returned on `rd_carry`.
- `ARITH_FIFO_CARRY_EN` undefined:
  - Entries are DATA_WIDTH bits and `carry_out` is ignored.
  - `rd_carry` is tied 0.
  - Port list is unchanged.

## Test plan
- Reset → `empty`=1, `full`=0, `count`=0, `overflow`=0, `rd_valid`=0; after release, write 0x1234 with carry 1 → next cycle `rd_valid`=1, `rd_data`=0x1234, `rd_carry`=1 (0 with macro undefined).
- Write 8 values 0x0001..0x0008 with `rd_ready`=0 → `full`=1, `count`=8. Ninth write of 0x0009 → `overflow`=1 and contents unchanged. Drain → reads 0x0001..0x0008 in order, then `empty`=1.
- When full, assert `arith_flag` with 0x00AA and `rd_ready`=1 in the same cycle → `count` stays 8, `overflow` stays 0, and 0x00AA is read last.
- When empty, assert `arith_flag`=1 (0x0055) and `rd_ready`=1 → `count`=1, `rd_data`=0x0055, no underflow.
- Continuous `arith_flag` with `rd_ready`=1 for 20 cycles (values 0..19) → outputs 0..19 in order at one per cycle, pointers wrap twice, `count` ≤1.
- Assert `RST` low with `count`=5 → `count`=0 and `rd_valid`=0 immediately (async). Raise `clr_ovf` together with an overflowing write → `overflow` stays 1.
